// File: rtl/axi_addr_arbiter_rr_if.sv
// Address-channel bundle between N upstream masters and one slave-side AR/AW channel.
// Latency: none, signal container only.
// Backpressure: READY_M from the slave, fanned back out as per-master READY_IN.
//
// Ports (signals):
//   ID_IN/ADDR_IN/LEN_IN/SIZE_IN/BURST_IN/VALID_IN : per-master request fields, master i at slice i
//   READY_IN                                       : per-master READY back to the masters
//   ID_M/ADDR_M/LEN_M/SIZE_M/BURST_M/VALID_M       : forwarded request, ID_M = {tag, ID}
//   READY_M                                        : slave READY
// Modports: slave = arbiter view, master = request-side driver (bench / upstream fabric).
interface axi_addr_arbiter_rr_if #(
  parameter int NUM_MASTERS = 4,
  parameter int ID_BITS     = 4,
  parameter int MID_BITS    = 4,
  parameter int ADDR_BITS   = 32,
  parameter int LEN_BITS    = 4,
  parameter int SIZE_BITS   = 3
);
  logic [NUM_MASTERS*ID_BITS-1:0]   ID_IN;
  logic [NUM_MASTERS*ADDR_BITS-1:0] ADDR_IN;
  logic [NUM_MASTERS*LEN_BITS-1:0]  LEN_IN;
  logic [NUM_MASTERS*SIZE_BITS-1:0] SIZE_IN;
  logic [NUM_MASTERS*2-1:0]         BURST_IN;
  logic [NUM_MASTERS-1:0]           VALID_IN;
  logic [NUM_MASTERS-1:0]           READY_IN;

  logic [MID_BITS+ID_BITS-1:0]      ID_M;
  logic [ADDR_BITS-1:0]             ADDR_M;
  logic [LEN_BITS-1:0]              LEN_M;
  logic [SIZE_BITS-1:0]             SIZE_M;
  logic [1:0]                       BURST_M;
  logic                             VALID_M;
  logic                             READY_M;

  modport slave (
    input  ID_IN, ADDR_IN, LEN_IN, SIZE_IN, BURST_IN, VALID_IN, READY_M,
    output READY_IN, ID_M, ADDR_M, LEN_M, SIZE_M, BURST_M, VALID_M
  );

  modport master (
    output ID_IN, ADDR_IN, LEN_IN, SIZE_IN, BURST_IN, VALID_IN, READY_M,
    input  READY_IN, ID_M, ADDR_M, LEN_M, SIZE_M, BURST_M, VALID_M
  );
endinterface

// File: rtl/axi_addr_arbiter_rr.sv
// N-master AXI address-channel arbiter, round-robin (MODE=0) or fixed priority (MODE=1).
// Latency: zero-cycle forwarding when idle; one empty cycle after a transfer that had to lock.
// Backpressure: grant locked from first VALID until READY_M handshake; READY_IN only to the granted master.
//
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   bus       : axi_addr_arbiter_rr_if.slave, master requests in / forwarded request out
//   grant_idx : currently selected master, 0 when nothing is selected
module axi_addr_arbiter_rr #(
  parameter int NUM_MASTERS = 4,
  parameter int ID_BITS     = 4,
  parameter int MID_BITS    = 4,
  parameter int ADDR_BITS   = 32,
  parameter int LEN_BITS    = 4,
  parameter int SIZE_BITS   = 3,
  parameter int MODE        = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  axi_addr_arbiter_rr_if.slave           bus,
  output logic [$clog2(NUM_MASTERS)-1:0] grant_idx
);

  localparam int IDX_W = $clog2(NUM_MASTERS);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]       state_q;
  logic [IDX_W-1:0] lock_idx_q;
  logic [IDX_W-1:0] rr_ptr_q;
  // Set for the single cycle after a locked transfer completes; nothing is
  // granted in that cycle and arbitration resumes on the next one.
  logic             gap_q;

  logic [IDX_W-1:0]    win_idx;
  logic                win_found;
  logic [IDX_W-1:0]    sel_idx;
  logic                sel_vld;
  logic [MID_BITS-1:0] tag;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NUM_MASTERS - 1)) ? '0 : i + IDX_W'(1);
  endfunction

  // Winner search. Round-robin walks rr_ptr, rr_ptr+1, ... with wrap;
  // fixed priority walks from index 0, so rr_ptr is simply ignored.
  always_comb begin
    logic [IDX_W:0] cand;
    cand      = '0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (MODE == 1) begin
        cand = (IDX_W+1)'(k);
      end else begin
        cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
        if (cand >= (IDX_W+1)'(NUM_MASTERS)) begin
          cand = cand - (IDX_W+1)'(NUM_MASTERS);
        end
      end
      if (!win_found && bus.VALID_IN[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // A locked grant never re-arbitrates; if its master drops VALID the
  // cycle simply carries nothing.
  always_comb begin
    sel_idx = '0;
    sel_vld = 1'b0;
    if (state_q == ST_LOCKED) begin
      sel_idx = lock_idx_q;
      sel_vld = bus.VALID_IN[lock_idx_q];
    end else if (!gap_q) begin
      sel_idx = win_idx;
      sel_vld = win_found;
    end
  end

  // Tag is index+1 so tag 0 is reserved for "nothing selected".
  assign tag = MID_BITS'(sel_idx) + MID_BITS'(1);

  always_comb begin
    bus.READY_IN = '0;
    bus.ID_M     = '0;
    bus.ADDR_M   = '0;
    bus.LEN_M    = '0;
    bus.SIZE_M   = '0;
    bus.BURST_M  = '0;
    bus.VALID_M  = 1'b0;
    grant_idx    = '0;
    if (sel_vld) begin
      grant_idx             = sel_idx;
      bus.ID_M              = {tag, bus.ID_IN[int'(sel_idx)*ID_BITS +: ID_BITS]};
      bus.ADDR_M            = bus.ADDR_IN[int'(sel_idx)*ADDR_BITS +: ADDR_BITS];
      bus.LEN_M             = bus.LEN_IN[int'(sel_idx)*LEN_BITS +: LEN_BITS];
      bus.SIZE_M            = bus.SIZE_IN[int'(sel_idx)*SIZE_BITS +: SIZE_BITS];
      bus.BURST_M           = bus.BURST_IN[int'(sel_idx)*2 +: 2];
      bus.VALID_M           = 1'b1;
      bus.READY_IN[sel_idx] = bus.READY_M;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      lock_idx_q <= '0;
      rr_ptr_q   <= '0;
      gap_q      <= 1'b0;
    end else begin
      gap_q <= 1'b0;
      if (state_q == ST_LOCKED) begin
        if (!bus.VALID_IN[lock_idx_q]) begin
          // Request withdrawn mid-lock: release without moving the pointer.
          state_q <= ST_IDLE;
        end else if (bus.READY_M) begin
          state_q  <= ST_IDLE;
          rr_ptr_q <= next_idx(lock_idx_q);
          gap_q    <= 1'b1;
        end
      end else if (sel_vld) begin
        if (bus.READY_M) begin
          rr_ptr_q <= next_idx(sel_idx);
        end else begin
          state_q    <= ST_LOCKED;
          lock_idx_q <= sel_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_addr_arbiter_rr.sv
// Bench for axi_addr_arbiter_rr: a round-robin and a fixed-priority instance share the
// same master-side stimulus; each is compared every cycle against a transaction-level
// model of grant ownership, plus directed scenarios with hand-computed expectations.
module tb_axi_addr_arbiter_rr;
  localparam int N    = 4;
  localparam int IDW  = 4;
  localparam int MIDW = 4;
  localparam int AW   = 32;
  localparam int LW   = 4;
  localparam int SW   = 3;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] gidx0, gidx1;

  always #5 clk = ~clk;

  axi_addr_arbiter_rr_if #(.NUM_MASTERS(N), .ID_BITS(IDW), .MID_BITS(MIDW),
                           .ADDR_BITS(AW), .LEN_BITS(LW), .SIZE_BITS(SW)) bus0 ();
  axi_addr_arbiter_rr_if #(.NUM_MASTERS(N), .ID_BITS(IDW), .MID_BITS(MIDW),
                           .ADDR_BITS(AW), .LEN_BITS(LW), .SIZE_BITS(SW)) bus1 ();

  assign bus1.ID_IN    = bus0.ID_IN;
  assign bus1.ADDR_IN  = bus0.ADDR_IN;
  assign bus1.LEN_IN   = bus0.LEN_IN;
  assign bus1.SIZE_IN  = bus0.SIZE_IN;
  assign bus1.BURST_IN = bus0.BURST_IN;
  assign bus1.VALID_IN = bus0.VALID_IN;
  assign bus1.READY_M  = bus0.READY_M;

  axi_addr_arbiter_rr #(.NUM_MASTERS(N), .ID_BITS(IDW), .MID_BITS(MIDW), .ADDR_BITS(AW),
                        .LEN_BITS(LW), .SIZE_BITS(SW), .MODE(0))
    u_rr (.clk(clk), .rst(rst), .bus(bus0), .grant_idx(gidx0));

  axi_addr_arbiter_rr #(.NUM_MASTERS(N), .ID_BITS(IDW), .MID_BITS(MIDW), .ADDR_BITS(AW),
                        .LEN_BITS(LW), .SIZE_BITS(SW), .MODE(1))
    u_fp (.clk(clk), .rst(rst), .bus(bus1), .grant_idx(gidx1));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: who owns the channel. owner[m] >= 0 means a request is
  // stuck waiting for READY; after such a transfer one cycle is left empty.
  int owner[2];
  int ptr[2];
  int empty_next[2];

  function automatic int pick(int m);
    int c;
    if (owner[m] >= 0) return bus0.VALID_IN[owner[m]] ? owner[m] : -1;
    if (empty_next[m] != 0) return -1;
    for (int k = 0; k < N; k++) begin
      c = (m == 1) ? k : (ptr[m] + k) % N;
      if (bus0.VALID_IN[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_step(input int m, input int s);
    int was_owned;
    was_owned     = (owner[m] >= 0);
    empty_next[m] = 0;
    if (rst) begin
      owner[m] = -1;
      ptr[m]   = 0;
    end else if (s >= 0) begin
      if (bus0.READY_M) begin
        owner[m] = -1;
        ptr[m]   = (s + 1) % N;
        if (was_owned != 0) empty_next[m] = 1;
      end else begin
        owner[m] = s;
      end
    end else begin
      owner[m] = -1;
    end
  endtask

  task automatic check_inst(input string p, input int s, input logic [7:0] id_m,
                            input logic [31:0] addr_m, input logic [3:0] len_m,
                            input logic [2:0] size_m, input logic [1:0] burst_m,
                            input logic vld_m, input logic [3:0] rdy_in, input logic [1:0] g);
    logic [63:0] e_id, e_addr, e_len, e_size, e_burst, e_rdy, e_g;
    e_id = 0; e_addr = 0; e_len = 0; e_size = 0; e_burst = 0; e_rdy = 0; e_g = 0;
    if (s >= 0) begin
      e_id    = ((s + 1) << IDW) | 64'(bus0.ID_IN[s*IDW +: IDW]);
      e_addr  = 64'(bus0.ADDR_IN[s*AW +: AW]);
      e_len   = 64'(bus0.LEN_IN[s*LW +: LW]);
      e_size  = 64'(bus0.SIZE_IN[s*SW +: SW]);
      e_burst = 64'(bus0.BURST_IN[s*2 +: 2]);
      e_rdy   = bus0.READY_M ? (64'd1 << s) : 64'd0;
      e_g     = 64'(s);
    end
    chk({p, ".valid_m"}, 64'(vld_m), (s >= 0) ? 64'd1 : 64'd0);
    chk({p, ".id_m"},    64'(id_m),    e_id);
    chk({p, ".addr_m"},  64'(addr_m),  e_addr);
    chk({p, ".len_m"},   64'(len_m),   e_len);
    chk({p, ".size_m"},  64'(size_m),  e_size);
    chk({p, ".burst_m"}, 64'(burst_m), e_burst);
    chk({p, ".ready_in"},64'(rdy_in),  e_rdy);
    chk({p, ".grant"},   64'(g),       e_g);
  endtask

  task automatic run_cycle();
    int s0, s1;
    @(negedge clk);
    s0 = pick(0);
    s1 = pick(1);
    check_inst("rr", s0, bus0.ID_M, bus0.ADDR_M, bus0.LEN_M, bus0.SIZE_M, bus0.BURST_M,
               bus0.VALID_M, bus0.READY_IN, gidx0);
    check_inst("fp", s1, bus1.ID_M, bus1.ADDR_M, bus1.LEN_M, bus1.SIZE_M, bus1.BURST_M,
               bus1.VALID_M, bus1.READY_IN, gidx1);
    @(posedge clk);
    model_step(0, s0);
    model_step(1, s1);
    #1;
  endtask

  task automatic set_master(input int i, input logic [3:0] id, input logic [31:0] addr);
    bus0.ID_IN[i*IDW +: IDW]  = id;
    bus0.ADDR_IN[i*AW +: AW]  = addr;
    bus0.LEN_IN[i*LW +: LW]   = LW'($urandom);
    bus0.SIZE_IN[i*SW +: SW]  = SW'($urandom);
    bus0.BURST_IN[i*2 +: 2]   = 2'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus0.VALID_IN = '0;
    run_cycle();
    rst = 1'b0;
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      owner[m] = -1; ptr[m] = 0; empty_next[m] = 0;
    end
    rst = 1'b1;
    bus0.VALID_IN = '0;
    bus0.READY_M  = 1'b0;
    for (int i = 0; i < N; i++) set_master(i, 4'($urandom), $urandom);
    run_cycle();
    run_cycle();
    rst = 1'b0;

    // Idle after reset: everything zero.
    #2;
    chk("reset.valid_m", 64'(bus0.VALID_M), 64'd0);
    chk("reset.id_m", 64'(bus0.ID_M), 64'd0);
    run_cycle();

    // Single request from master 2 with ID 5.
    set_master(2, 4'h5, 32'h2000_0040);
    bus0.VALID_IN = 4'b0100;
    bus0.READY_M  = 1'b1;
    #2;
    chk("single.id_m", 64'(bus0.ID_M), 64'h35);
    chk("single.ready_in", 64'(bus0.READY_IN), 64'b0100);
    run_cycle();
    bus0.VALID_IN = 4'b1111;
    #2;
    chk("single.rr_next", 64'(gidx0), 64'd3);
    chk("single.fp_next", 64'(gidx1), 64'd0);
    run_cycle();

    // Fairness / fixed priority with all masters requesting.
    do_reset();
    bus0.VALID_IN = 4'b1111;
    bus0.READY_M  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #2;
      chk("fair.rr_grant", 64'(gidx0), 64'(i % 4));
      chk("fair.fp_grant", 64'(gidx1), 64'd0);
      run_cycle();
    end
    bus0.VALID_IN = 4'b1110;
    #2;
    chk("fp.drop0_grant", 64'(gidx1), 64'd1);
    run_cycle();

    // Lock hold: master 1 waits, master 0 joins but cannot steal the grant.
    do_reset();
    set_master(1, 4'h9, 32'hA000_1000);
    bus0.VALID_IN = 4'b0010;
    bus0.READY_M  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("lock.rr_addr", 64'(bus0.ADDR_M), 64'hA000_1000);
      chk("lock.rr_tag", 64'(bus0.ID_M[7:4]), 64'd2);
      chk("lock.fp_tag", 64'(bus1.ID_M[7:4]), 64'd2);
      run_cycle();
      bus0.VALID_IN = 4'b0011;
    end
    bus0.READY_M = 1'b1;
    #2;
    chk("lock.release_ready", 64'(bus0.READY_IN), 64'b0010);
    run_cycle();
    #2;
    chk("lock.gap_valid", 64'(bus0.VALID_M), 64'd0);
    run_cycle();
    #2;
    chk("lock.next_valid", 64'(bus0.VALID_M), 64'd1);
    chk("lock.next_grant", 64'(gidx0), 64'd0);
    run_cycle();

    // VALID withdrawn while locked; pointer must not move.
    do_reset();
    bus0.VALID_IN = 4'b0001;
    bus0.READY_M  = 1'b1;
    run_cycle();
    bus0.VALID_IN = 4'b1000;
    bus0.READY_M  = 1'b0;
    run_cycle();
    bus0.VALID_IN = 4'b0000;
    #2;
    chk("drop.valid_m", 64'(bus0.VALID_M), 64'd0);
    chk("drop.ready_in", 64'(bus0.READY_IN), 64'd0);
    run_cycle();
    bus0.VALID_IN = 4'b1111;
    bus0.READY_M  = 1'b1;
    #2;
    chk("drop.ptr_kept", 64'(gidx0), 64'd1);
    run_cycle();

    // Reset while locked.
    bus0.VALID_IN = 4'b0100;
    bus0.READY_M  = 1'b0;
    run_cycle();
    rst = 1'b1;
    bus0.VALID_IN = 4'b0000;
    run_cycle();
    rst = 1'b0;
    #2;
    chk("rstlock.valid_m", 64'(bus0.VALID_M), 64'd0);
    run_cycle();
    bus0.VALID_IN = 4'b1111;
    bus0.READY_M  = 1'b1;
    #2;
    chk("rstlock.rr_grant", 64'(gidx0), 64'd0);
    chk("rstlock.fp_grant", 64'(gidx1), 64'd0);
    run_cycle();

    // Randomized traffic, including VALID drops and occasional reset.
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < N; i++) set_master(i, 4'($urandom), $urandom);
      bus0.VALID_IN = 4'($urandom) & 4'($urandom | $urandom);
      bus0.READY_M  = ($urandom_range(0, 2) != 0);
      run_cycle();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/axi_addr_arbiter_rr.md
Name: axi_addr_arbiter_rr

Overview:
N-master AXI address-channel (AR or AW) arbiter; the parametrised successor of the two-master address arbiter. It sits in the AXI bridge in front of each slave-side address channel, selects one requesting master, and forwards its request with a master tag prepended to the ID. The grant is locked from first VALID until the READY handshake, so the forwarded payload stays stable per AXI rules. Round-robin or fixed-priority selection is chosen by parameter.

Parameters:
NUM_MASTERS, 4, number of master ports (2..15)
ID_BITS, 4, per-master AXI ID width
MID_BITS, 4, master-tag width prepended to ID; requires NUM_MASTERS <= 2**MID_BITS-1
ADDR_BITS, 32, address width
LEN_BITS, 4, burst length width
SIZE_BITS, 3, burst size width
MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)

Ports:
clk  in  1  clock
rst  in  1  reset; one clock; reset is synchronous and active-high
ID_IN  in  NUM_MASTERS*ID_BITS  master IDs, master i at slice i
ADDR_IN  in  NUM_MASTERS*ADDR_BITS  master addresses
LEN_IN  in  NUM_MASTERS*LEN_BITS  master burst lengths
SIZE_IN  in  NUM_MASTERS*SIZE_BITS  master burst sizes
BURST_IN  in  NUM_MASTERS*2  master burst types
VALID_IN  in  NUM_MASTERS  master VALIDs
READY_IN  out  NUM_MASTERS  per-master READY
ID_M  out  MID_BITS+ID_BITS  {tag, ID}; tag = granted index + 1
ADDR_M  out  ADDR_BITS  forwarded address
LEN_M  out  LEN_BITS  forwarded length
SIZE_M  out  SIZE_BITS  forwarded size
BURST_M  out  2  forwarded burst type
VALID_M  out  1  forwarded VALID
READY_M  in  1  slave READY
grant_idx  out  $clog2(NUM_MASTERS)  currently selected master (debug/monitor)

Behaviour:
- State: IDLE / LOCKED; lock_idx register; rr_ptr register (next highest-priority index).
- Reset (sync, rst=1 at clk edge): state=IDLE, lock_idx=0, rr_ptr=0. Outputs are combinational from state: with no VALID_IN, ID_M/ADDR_M/LEN_M/SIZE_M/BURST_M=0, VALID_M=0, READY_IN=0, grant_idx=0.
- IDLE: winner w selected combinationally from VALID_IN in the same cycle (zero latency). MODE=0: first set bit searching rr_ptr, rr_ptr+1, ... mod NUM_MASTERS. MODE=1: lowest set index.
- Forwarding: the selected master's fields drive the M side. ID_M = {w+1 in MID_BITS, ID_IN[w]}. VALID_M = VALID_IN[w]. READY_IN[w] = VALID_IN[w] & READY_M; all other READY_IN bits = 0.
- IDLE, winner exists, READY_M=1: handshake completes this cycle; stay IDLE; rr_ptr <= (w+1) mod NUM_MASTERS.
- IDLE, winner exists, READY_M=0: next state LOCKED, lock_idx <= w.
- LOCKED: selection is forced to lock_idx regardless of other VALIDs (no re-arbitration). On VALID_IN[lock_idx] & READY_M: handshake; next state IDLE; rr_ptr <= lock_idx+1 mod N. The next request is arbitrated in the following cycle, so there is one idle cycle after a locked transfer.
- LOCKED and VALID_IN[lock_idx]=0 (protocol violation): VALID_M=0 and READY_IN=0 this cycle. Next state IDLE with rr_ptr unchanged.
- MODE=1: rr_ptr is still updated but ignored.
- Back-to-back: a continuously ready slave accepts one request per cycle, rotating among all requesting masters.
- rst asserted while LOCKED: the lock is dropped and ptr is cleared at that edge. The master must re-present its request.
- Widths: tag arithmetic is w+1 truncated to MID_BITS; the parameter rule guarantees no tag 0 is issued to a master. Tag 0 appears only when nothing is selected.
- Fully synthesizable. No combinational path from READY_M to VALID_M.

Test Plan:
- Single request, N=4: VALID_IN=4'b0100, ID_IN[2]=4'h5, READY_M=1 -> same cycle VALID_M=1, ID_M=8'h35, READY_IN=4'b0100; rr_ptr becomes 3.
- Round-robin fairness, MODE=0: all VALID_IN=1111 held, READY_M=1 for 8 cycles -> grant_idx sequence 0,1,2,3,0,1,2,3 with one handshake per cycle.
- Lock hold: master1 requests with READY_M=0 for 3 cycles while master0 raises VALID -> ADDR_M stays master1's address and ID_M tag=2 throughout. READY_M=1 then completes master1; master0 is granted 2 cycles later.
- Fixed priority, MODE=1: VALID_IN=1111, READY_M=1 -> master0 granted every cycle; drop bit 0 -> master1 granted next cycle.
- Valid drop while LOCKED: lock master3, deassert VALID_IN[3] before READY -> VALID_M=0 that cycle, READY_IN=0, IDLE next cycle, rr_ptr unchanged.
- Reset mid-lock: assert rst for 1 cycle while LOCKED -> VALID_M=0 if no VALID_IN, rr_ptr=0; with VALID_IN=1111 after reset, master0 wins first.
